// File: rtl/tinyriscv_pkg.sv
// Shared core definitions: M-extension divide funct3 encodings
// and register-file address width.
package tinyriscv_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage issue/writeback controller for the iterative divider.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   req_*        decoded DIV/DIVU/REM/REMU request from EX
//   flush_i      kills the in-flight op
//   stall_o      holds IF/ID/EX
//   busy_o       controller is not idle
//   div_*_o      level-held request and operands to the divider
//   div_data_i, div_ready_i  divider result and done pulse
//   wb_*_o       single-cycle register-file writeback
//   timeout_o    one-cycle pulse when the watchdog aborts an op
module div_issue_ctrl
    import tinyriscv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic [2:0]            req_op_i,
    input  logic [WIDTH-1:0]      req_dividend_i,
    input  logic [WIDTH-1:0]      req_divisor_i,
    input  logic [REG_ADDR_W-1:0] req_rd_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  div_valid_o,
    output logic [WIDTH-1:0]      div_dividend_o,
    output logic [WIDTH-1:0]      div_divisor_o,
    output logic [2:0]            div_op_o,
    input  logic [WIDTH-1:0]      div_data_i,
    input  logic                  div_ready_i,
    output logic                  wb_we_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [WIDTH-1:0]      wb_data_o,
    output logic                  timeout_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]            state_q;
    logic [WD_W-1:0]       wd_q;
    logic [WIDTH-1:0]      dividend_q;
    logic [WIDTH-1:0]      divisor_q;
    logic [WIDTH-1:0]      result_q;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;

    logic req_ok;
    logic in_busy;
    logic in_wb;
    logic wd_expired;

    // funct3[2] set selects the divide/remainder group of OP-M.
    assign req_ok     = req_valid_i & req_op_i[2];
    assign in_busy    = (state_q == S_BUSY);
    assign in_wb      = (state_q == S_WB);
    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wd_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            result_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_ok && !flush_i) begin
                        dividend_q <= req_dividend_i;
                        divisor_q  <= req_divisor_i;
                        op_q       <= req_op_i;
                        rd_q       <= req_rd_i;
                        wd_q       <= '0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    wd_q <= wd_q + WD_W'(1);
                    // Flush beats a coincident ready; ready beats the watchdog.
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else if (div_ready_i) begin
                        result_q <= div_data_i;
                        state_q  <= S_WB;
                    end else if (wd_expired) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // WB drops stall for exactly one cycle so EX retires the op once.
    assign stall_o   = in_busy | (req_ok & ~flush_i & ~in_wb);
    assign busy_o    = (state_q != S_IDLE);
    assign timeout_o = in_busy & ~flush_i & ~div_ready_i & wd_expired;

    // Operands come straight from registers so they stay put while busy.
    assign div_valid_o    = in_busy;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_op_o       = op_q;

    assign wb_we_o   = in_wb & (rd_q != '0);
    assign wb_rd_o   = rd_q;
    assign wb_data_o = result_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl: behavioural divider plus
// reference result/latency model, directed and random scenarios.
module tb_div_issue_ctrl;

    localparam int W = 32;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0;
    logic [2:0]  req_op = 0;
    logic [31:0] req_a = 0;
    logic [31:0] req_b = 0;
    logic [4:0]  req_rd = 0;
    logic        flush = 0;
    logic        stall, busy, div_valid, div_ready, wb_we, timeout;
    logic [31:0] div_a, div_b, div_data, wb_data;
    logic [2:0]  div_op;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.WIDTH(32), .TIMEOUT(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_op_i(req_op),
        .req_dividend_i(req_a), .req_divisor_i(req_b),
        .req_rd_i(req_rd), .flush_i(flush),
        .stall_o(stall), .busy_o(busy),
        .div_valid_o(div_valid), .div_dividend_o(div_a),
        .div_divisor_o(div_b), .div_op_o(div_op),
        .div_data_i(div_data), .div_ready_i(div_ready),
        .wb_we_o(wb_we), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .timeout_o(timeout)
    );

    // RISC-V M-extension semantics.
    function automatic logic [31:0] ref_result(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int sa, sb;
        logic ovf;
        sa = $signed(a);
        sb = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Writeback cycle counted from the accept edge.
    function automatic int ref_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        bit special;
        special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return special ? 4 : W + 4;
    endfunction

    // Divider model: ready pulse after the required number of valid cycles.
    int dcnt = 0;
    bit withhold = 0;
    bit force_ready = 0;

    always @(posedge clk) begin
        if (rst || !div_valid) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    always_comb begin
        div_data  = ref_result(div_op, div_a, div_b);
        div_ready = force_ready ||
                    (div_valid && !withhold &&
                     dcnt == ref_lat(div_op, div_a, div_b) - 2);
    end

    task automatic set_req(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(posedge clk); #1;
        set_req(op, a, b, rd);
    endtask

    task automatic drop();
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    // Observes an op from cycle 0 until stall releases; no judging here.
    task automatic watch(input int maxc, input bit hold,
                         output int rel, output int nvalid, output int nwe,
                         output logic we, output logic [4:0] rd,
                         output logic [31:0] data, output int to_cyc,
                         output int nto, output logic stall0);
        rel = -1; nvalid = 0; nwe = 0; we = 0; rd = 0; data = 0;
        to_cyc = -1; nto = 0;
        @(negedge clk);
        stall0 = stall;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk);
            if (c == 1 && !hold) begin #1; req_valid = 0; end
            @(negedge clk);
            if (div_valid) nvalid++;
            if (wb_we) nwe++;
            if (timeout) begin nto++; if (to_cyc < 0) to_cyc = c; end
            if (!stall) begin
                rel = c; we = wb_we; rd = wb_rd; data = wb_data;
                break;
            end
        end
    endtask

    int rel, nvalid, nwe, to_cyc, nto;
    logic we, st0;
    logic [4:0] rd_o;
    logic [31:0] data_o;

    task automatic test_reset();
        rst = 1; req_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, busy, div_valid, div_a, div_b, div_op, wb_we, wb_rd, wb_data, timeout} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero output(s) busy=%b valid=%b we=%b", busy, div_valid, wb_we);
        end
        rst = 0;
    endtask

    task automatic test_ignored_op();
        @(posedge clk); #1;
        set_req(3'b001, 32'd5, 32'd2, 5'd3);
        force_ready = 1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL ignored_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        force_ready = 0; req_valid = 0;
        checks++;
        if ({busy, wb_we} !== 2'b00) begin errors++; $display("FAIL ignored_accept: got busy=%b we=%b expected 0", busy, wb_we); end
    endtask

    task automatic test_divu_basic();
        issue(3'b101, 32'd100, 32'd7, 5'd5);
        watch(60, 1, rel, nvalid, nwe, we, rd_o, data_o, to_cyc, nto, st0);
        drop();
        checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL divu_stall0: got %b expected 1", st0); end
        checks++; if (rel !== 36) begin errors++; $display("FAIL divu_wb_cycle: got %0d expected 36", rel); end
        checks++; if (nvalid !== 35) begin errors++; $display("FAIL divu_valid_cycles: got %0d expected 35", nvalid); end
        checks++; if ({we, rd_o} !== {1'b1, 5'd5}) begin errors++; $display("FAIL divu_we_rd: got %b/%0d expected 1/5", we, rd_o); end
        checks++; if (data_o !== 32'd14) begin errors++; $display("FAIL divu_data: got %0h expected e", data_o); end
        checks++; if (nwe !== 1) begin errors++; $display("FAIL divu_we_count: got %0d expected 1", nwe); end
        @(negedge clk);
        checks++; if ({stall, wb_we} !== 2'b00) begin errors++; $display("FAIL divu_after: got stall=%b we=%b expected 0", stall, wb_we); end
    endtask

    // Directed case with hard-coded expectations.
    task automatic test_directed(input string nm, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_d, input int exp_c);
        issue(op, a, b, rd);
        watch(60, 1, rel, nvalid, nwe, we, rd_o, data_o, to_cyc, nto, st0);
        checks++; if (rel !== exp_c) begin errors++; $display("FAIL %s_cycle: got %0d expected %0d", nm, rel, exp_c); end
        checks++; if (data_o !== exp_d) begin errors++; $display("FAIL %s_data: got %0h expected %0h", nm, data_o, exp_d); end
        checks++; if (nwe !== (rd != 0 ? 1 : 0)) begin errors++; $display("FAIL %s_we: got %0d expected %0d", nm, nwe, rd != 0); end
    endtask

    task automatic test_special();
        test_directed("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFF, 36);
        test_directed("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, 4);
        test_directed("div_zero", 3'b100, 32'd1234, 32'd0, 5'd3, 32'hFFFF_FFFF, 4);
        test_directed("remu_zero", 3'b111, 32'd1234, 32'd0, 5'd4, 32'd1234, 4);
        test_directed("rd_zero", 3'b101, 32'd50, 32'd5, 5'd0, 32'd10, 36);
        drop();
    endtask

    task automatic test_flush();
        nwe = 0;
        issue(3'b100, 32'd1000, 32'd3, 5'd6);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin flush = 1; req_valid = 0; end
            @(negedge clk);
            if (wb_we) nwe++;
        end
        @(posedge clk); #1;
        flush = 0;
        checks++; if ({div_valid, busy, wb_we} !== 3'b000) begin errors++; $display("FAIL flush_kill: got valid=%b busy=%b we=%b expected 0", div_valid, busy, wb_we); end
        checks++; if (nwe !== 0) begin errors++; $display("FAIL flush_no_wb: got %0d expected 0", nwe); end
        set_req(3'b101, 32'd9, 32'd3, 5'd7);
        watch(60, 1, rel, nvalid, nwe, we, rd_o, data_o, to_cyc, nto, st0);
        drop();
        checks++; if (rel !== 36) begin errors++; $display("FAIL flush_next_cycle: got %0d expected 36", rel); end
        checks++; if ({we, rd_o, data_o} !== {1'b1, 5'd7, 32'd3}) begin errors++; $display("FAIL flush_next_wb: got %b/%0d/%0h expected 1/7/3", we, rd_o, data_o); end
    endtask

    task automatic test_flush_ready();
        logic rdy_seen;
        rdy_seen = 0; nwe = 0;
        issue(3'b101, 32'd77, 32'd7, 5'd8);
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            if (c == 35) begin flush = 1; req_valid = 0; end
            @(negedge clk);
            if (c == 35) rdy_seen = div_ready;
        end
        @(posedge clk); #1;
        flush = 0;
        checks++; if (rdy_seen !== 1'b1) begin errors++; $display("FAIL flrdy_ready: got %b expected 1", rdy_seen); end
        checks++; if ({busy, stall, div_valid} !== 3'b000) begin errors++; $display("FAIL flrdy_idle: got busy=%b stall=%b valid=%b expected 0", busy, stall, div_valid); end
        repeat (4) begin @(negedge clk); if (wb_we) nwe++; end
        checks++; if (nwe !== 0) begin errors++; $display("FAIL flrdy_no_wb: got %0d expected 0", nwe); end
    endtask

    task automatic test_reset_mid();
        nwe = 0;
        issue(3'b100, 32'd500, 32'd9, 5'd9);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 20) begin rst = 1; req_valid = 0; end
        end
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if ({stall, busy, div_valid, div_a, div_b, div_op, wb_we, wb_rd, wb_data, timeout} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got busy=%b valid=%b a=%0h data=%0h expected 0", busy, div_valid, div_a, wb_data);
        end
        repeat (40) begin @(negedge clk); if (wb_we) nwe++; end
        checks++; if ({nwe, dcnt} !== 64'd0) begin errors++; $display("FAIL rstmid_quiet: got we=%0d dcnt=%0d expected 0", nwe, dcnt); end
    endtask

    task automatic test_timeout();
        withhold = 1;
        issue(3'b110, 32'd33, 32'd4, 5'd10);
        watch(100, 0, rel, nvalid, nwe, we, rd_o, data_o, to_cyc, nto, st0);
        withhold = 0;
        checks++; if ({to_cyc, nto} !== {32'd64, 32'd1}) begin errors++; $display("FAIL timeout_pulse: got cycle %0d count %0d expected 64/1", to_cyc, nto); end
        checks++; if (rel !== 65) begin errors++; $display("FAIL timeout_release: got %0d expected 65", rel); end
        checks++; if (nwe !== 0) begin errors++; $display("FAIL timeout_no_wb: got %0d expected 0", nwe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        test_directed("b2b_div", 3'b100, 32'hFFFF_FF9C, 32'd7, 5'd11, 32'hFFFF_FFF2, 36);
        test_directed("b2b_rem", 3'b110, 32'hFFFF_FF9C, 32'd7, 5'd12, 32'hFFFF_FFFE, 36);
        drop();
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        logic [4:0] rd;
        for (int n = 0; n < 16; n++) begin
            op = 3'(4 + $urandom_range(0, 3));
            a = $urandom;
            b = $urandom_range(0, 3) == 0 ? 32'(($urandom & 32'hFF) + 1) : $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            rd = 5'($urandom_range(0, 31));
            issue(op, a, b, rd);
            watch(60, 1, rel, nvalid, nwe, we, rd_o, data_o, to_cyc, nto, st0);
            checks++;
            if (rel !== ref_lat(op, a, b) || data_o !== ref_result(op, a, b) ||
                nwe !== (rd != 0 ? 1 : 0) || rd_o !== rd || div_a !== a || div_b !== b) begin
                errors++;
                $display("FAIL rand_%0d: got cyc=%0d data=%0h we=%0d rd=%0d expected cyc=%0d data=%0h rd=%0d (op=%0d a=%0h b=%0h)",
                         n, rel, data_o, nwe, rd_o, ref_lat(op, a, b), ref_result(op, a, b), rd, op, a, b);
            end
        end
        drop();
    endtask

    initial begin
        test_reset();
        test_ignored_op();
        test_divu_basic();
        test_special();
        test_flush();
        test_flush_ready();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
